// File: rtl/circle_engine.sv
// circle_engine: moves up to eight circles and renders them onto a scanned
// pixel stream.
//
// Per-circle state (centre and direction bits) changes only on frame_tick.
// In manual mode the selected circle moves and is clamped to the screen. In
// auto mode every circle bounces off the edges. The pixel path is a 2-stage
// pipeline:
//   - stage 1 registers the coordinate differences;
//   - stage 2 registers the colour.
// A per-frame accumulator records whether any pixel was covered by two or
// more circles.
//
// Ports:
//   clk, reset               clock; synchronous active-high reset
//   frame_tick               one-cycle pulse per frame, during blanking
//   up, down, left, right    manual move requests, sampled on frame_tick
//   sel                      index of the manually controlled circle
//   auto_mode                1 = all circles bounce autonomously
//   coord_x, coord_y         pixel under scan
//   active_area              pixel under scan is visible
//   rgb                      pixel colour, two cycles after the coordinate
//   collide                  previous frame contained an overlap pixel
module circle_engine #(
  parameter int         N_OBJ    = 2,
  parameter int         RADIUS   = 25,
  parameter int         STEP     = 1,
  parameter int         H_ACTIVE = 640,
  parameter int         V_ACTIVE = 480,
  parameter logic [2:0] BG_COLOR = 3'b010
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       frame_tick,
  input  logic       up,
  input  logic       down,
  input  logic       left,
  input  logic       right,
  input  logic [2:0] sel,
  input  logic       auto_mode,
  input  logic [9:0] coord_x,
  input  logic [9:0] coord_y,
  input  logic       active_area,
  output logic [2:0] rgb,
  output logic       collide
);

  // Position arithmetic is done in 12-bit signed so that a step below zero
  // or above 1023 is caught by the clamp instead of wrapping.
  localparam logic signed [11:0] X_LO   = 12'(RADIUS);
  localparam logic signed [11:0] X_HI   = 12'(H_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0] Y_LO   = 12'(RADIUS);
  localparam logic signed [11:0] Y_HI   = 12'(V_ACTIVE - 1 - RADIUS);
  localparam logic signed [11:0] STEP_S = 12'(STEP);
  localparam logic [21:0]        R_SQ   = 22'(RADIUS * RADIUS);

  logic [N_OBJ-1:0] in_flag;
  logic             act1_reg;
  logic             acc_reg;
  logic [2:0]       pix_color;
  logic [3:0]       hit_cnt;
  logic             overlap;

  genvar gi;
  generate
    for (gi = 0; gi < N_OBJ; gi++) begin : g_obj
      logic [9:0]         cx_reg, cy_reg, cx_next, cy_next;
      logic               vx_reg, vy_reg, vx_next, vy_next;
      logic signed [11:0] x_cur, y_cur, x_mv, y_mv;
      logic signed [10:0] dx_reg, dy_reg;
      logic signed [21:0] dx_w, dy_w;
      logic [21:0]        sq_x, sq_y, dist_sq;
      logic               sel_hit;

      // sel is 3 bits and gi < 8, so an out-of-range sel matches nothing.
      assign sel_hit = (sel == 3'(gi));
      assign x_cur   = {2'b00, cx_reg};
      assign y_cur   = {2'b00, cy_reg};

      always_comb begin
        cx_next = cx_reg;
        cy_next = cy_reg;
        vx_next = vx_reg;
        vy_next = vy_reg;
        x_mv    = x_cur;
        y_mv    = y_cur;
        if (auto_mode) begin
          x_mv    = vx_reg ? x_cur + STEP_S : x_cur - STEP_S;
          y_mv    = vy_reg ? y_cur + STEP_S : y_cur - STEP_S;
          cx_next = x_mv[9:0];
          cy_next = y_mv[9:0];
          // Reaching a bound (not only passing it) reverses the axis.
          if (vx_reg && x_mv >= X_HI) begin
            cx_next = X_HI[9:0];
            vx_next = 1'b0;
          end else if (!vx_reg && x_mv <= X_LO) begin
            cx_next = X_LO[9:0];
            vx_next = 1'b1;
          end
          if (vy_reg && y_mv >= Y_HI) begin
            cy_next = Y_HI[9:0];
            vy_next = 1'b0;
          end else if (!vy_reg && y_mv <= Y_LO) begin
            cy_next = Y_LO[9:0];
            vy_next = 1'b1;
          end
        end else if (sel_hit) begin
          if (right && !left)      x_mv = x_cur + STEP_S;
          else if (left && !right) x_mv = x_cur - STEP_S;
          if (down && !up)         y_mv = y_cur + STEP_S;
          else if (up && !down)    y_mv = y_cur - STEP_S;
          if (x_mv > X_HI)         cx_next = X_HI[9:0];
          else if (x_mv < X_LO)    cx_next = X_LO[9:0];
          else                     cx_next = x_mv[9:0];
          if (y_mv > Y_HI)         cy_next = Y_HI[9:0];
          else if (y_mv < Y_LO)    cy_next = Y_LO[9:0];
          else                     cy_next = y_mv[9:0];
        end
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          cx_reg <= 10'(100 + 60 * gi);
          cy_reg <= 10'd100;
          vx_reg <= 1'b1;
          vy_reg <= 1'b1;
          dx_reg <= '0;
          dy_reg <= '0;
        end else begin
          if (frame_tick) begin
            cx_reg <= cx_next;
            cy_reg <= cy_next;
            vx_reg <= vx_next;
            vy_reg <= vy_next;
          end
          // Uses the registered centre, so a tick affects the next pixel.
          dx_reg <= $signed({1'b0, coord_x}) - $signed({1'b0, cx_reg});
          dy_reg <= $signed({1'b0, coord_y}) - $signed({1'b0, cy_reg});
        end
      end

      // 22 bits hold 2*1023^2, so the sum of squares cannot wrap.
      assign dx_w        = 22'(dx_reg);
      assign dy_w        = 22'(dy_reg);
      assign sq_x        = dx_w * dx_w;
      assign sq_y        = dy_w * dy_w;
      assign dist_sq     = sq_x + sq_y;
      assign in_flag[gi] = (dist_sq <= R_SQ);
    end
  endgenerate

  // Walk from the highest index down so the lowest-index hit wins.
  always_comb begin
    pix_color = BG_COLOR;
    hit_cnt   = '0;
    for (int i = N_OBJ - 1; i >= 0; i--) begin
      if (in_flag[i]) begin
        pix_color = 3'((i % 6) + 1);
        hit_cnt   = hit_cnt + 4'd1;
      end
    end
  end

  assign overlap = act1_reg && (hit_cnt >= 4'd2);

  always_ff @(posedge clk) begin
    if (reset) begin
      act1_reg <= 1'b0;
      rgb      <= 3'b000;
      collide  <= 1'b0;
      acc_reg  <= 1'b0;
    end else begin
      act1_reg <= active_area;
      rgb      <= act1_reg ? pix_color : 3'b000;
      if (frame_tick) begin
        collide <= acc_reg;
        // An overlap pixel arriving with the tick belongs to the new frame.
        acc_reg <= overlap;
      end else begin
        acc_reg <= acc_reg | overlap;
      end
    end
  end

endmodule

// File: doc/circle_engine.md
CIRCLE_ENGINE -- requirements
Module: circle_engine

Interface
REQ-001 SHALL provide parameter N_OBJ, default 2: number of circles, 1..8.
REQ-002 SHALL provide parameter RADIUS, default 25: circle radius in pixels.
REQ-003 SHALL provide parameter STEP, default 1: pixels moved per frame per axis.
REQ-004 SHALL provide parameters H_ACTIVE, default 640, and V_ACTIVE, default 480: visible area size.
REQ-005 SHALL provide parameter BG_COLOR, default 3'b010: background colour.
REQ-006 SHALL have ports clk (in, 1, clock); reset (in, 1, synchronous, active-high).
REQ-007 SHALL have frame_tick (in, 1): one-cycle pulse, once per frame, during blanking.
REQ-008 SHALL have up, down, left, right (in, 1 each): manual move requests.
REQ-009 SHALL have sel (in, 3): index of the manually controlled circle.
REQ-010 SHALL have auto_mode (in, 1): 1 = all circles bounce autonomously.
REQ-011 SHALL have coord_x, coord_y (in, 10 each) and active_area (in, 1): pixel under scan.
REQ-012 SHALL have rgb (out, 3): pixel colour.
REQ-013 SHALL have collide (out, 1): previous frame contained at least one overlap pixel.

Function
REQ-014 SHALL hold per circle i: cx_i, cy_i (10 bit each), and direction bits vx_i, vy_i (1 = +, 0 = -).
REQ-015 SHALL update positions only in the cycle frame_tick=1; otherwise positions are held.
REQ-016 Manual mode (auto_mode=0): only circle sel moves, by STEP; up -> y-STEP, down -> y+STEP, left -> x-STEP, right -> x+STEP.
REQ-017 Manual mode: up&down together leaves y unchanged; left&right together leaves x unchanged.
REQ-018 Manual mode: sel >= N_OBJ moves no circle.
REQ-019 Manual mode: direction inputs SHALL be ignored on cycles where frame_tick=0.
REQ-020 Clamp: cx SHALL stay in [RADIUS, H_ACTIVE-1-RADIUS] and cy in [RADIUS, V_ACTIVE-1-RADIUS]; an out-of-range result saturates to the bound.
REQ-021 Auto mode: every circle moves STEP per axis in its vx/vy direction; direction inputs and sel are ignored.
REQ-022 Auto mode, bounce: when a move would reach or pass a bound, the position SHALL be set to that bound and the axis direction bit inverted, in the same tick.
REQ-023 Pixel path SHALL be a 2-stage pipeline; rgb at cycle t+2 reflects coord_x, coord_y and active_area at cycle t.
REQ-024 Stage 1 SHALL register the signed 11-bit differences (coord - centre) for each circle, plus active_area.
REQ-025 Stage 2 SHALL compute dx*dx + dy*dy at 22-bit width and flag in_i when the sum <= RADIUS*RADIUS; no wrap-around is permitted.
REQ-026 Circle colour i SHALL be ((i mod 6) + 1) on 3 bits, so circle 0 is 3'b001.
REQ-027 rgb SHALL be 0 when inactive, else the colour of the lowest-index circle with in_i=1, else BG_COLOR.
REQ-028 A pixel that is active and has two or more in_i flags set is an overlap pixel.
REQ-029 An internal accumulator acc SHALL be set by any overlap pixel reaching stage 2.
REQ-030 On frame_tick: collide <= acc; acc is cleared. An overlap pixel in the same cycle counts toward the new frame.
REQ-031 Positions sampled by the pixel pipeline SHALL be the registered values; a frame_tick update affects pixels entering stage 1 from the following cycle.

Reset
REQ-032 On reset: cx_i = 100 + 60*i, cy_i = 100, vx_i = vy_i = 1.
REQ-033 On reset: pipeline registers cleared; rgb = 0, collide = 0, acc = 0 in the next cycle.
REQ-034 Reset SHALL take priority over frame_tick and all other inputs.
REQ-035 Reset asserted mid-frame SHALL discard in-flight pixels; rgb is 0 until valid pixels traverse both stages.

Verification
REQ-036 After reset, drive pixel (100,100) active -> rgb = 3'b001 two cycles later; pixel (100,126) -> BG_COLOR; active_area = 0 -> 3'b000.
REQ-037 Manual mode, sel=1, right=1, one frame_tick -> cx_1 = 161; then pixel (186,100) -> 3'b010, pixel (187,100) -> BG_COLOR; up&down with frame_tick -> cy_1 unchanged.
REQ-038 Manual mode: left held for 200 frame_ticks on circle 0 -> cx_0 saturates at 25 and stays there; sel=5 with N_OBJ=2 -> no circle moves.
REQ-039 Auto mode, STEP=1: circle 0 from reset reaches cx = 614 after 514 ticks, then vx_0 = 0 and next tick gives cx = 613.
REQ-040 Move circle 1 to (120,100), scan a frame including pixel (110,100), then frame_tick -> collide=1 and rgb at (110,100) = 3'b001; a following frame with no overlap -> collide=0 after the next tick.
REQ-041 Assert reset during an active scanline with collide=1 -> next cycle rgb=0, collide=0, centres at reset values.
